im_fetch_master: RTL and testbench
==================================

# im_fetch_master

CPU instruction-fetch AXI read master. Converts single-word fetch requests from the CPU IF stage into single-beat AXI INCR read transactions toward the interconnect, whose read slaves include the boot ROM wrapper. Returns the fetched word with a one-cycle valid pulse and drops any response whose request was flushed by a redirect. Read-only: it has no AW/W/B channels; the interconnect ties those master ports off.

## Interface
- MASTER_ID, default `AXI_ID_BITS'd0: value driven on M_ARID.
- ACLK  in  1  clock, all state on rising edge.
- ARESETn  in  1  reset, synchronous, active-low; clock ACLK.
- fetch_req  in  1  CPU fetch request; held with fetch_addr until fetch_valid.
- fetch_addr  in  32  byte address; bits [1:0] ignored.
- flush  in  1  one-cycle redirect pulse; cancels the in-flight fetch.
- fetch_valid  out  1  one-cycle pulse, fetch_data/fetch_err valid.
- fetch_data  out  32  fetched instruction word, registered.
- fetch_err  out  1  RResp was not OKAY for this fetch.
- fetch_stall  out  1  fetch_req & ~fetch_valid (combinational).
- M_ARID  out  `AXI_ID_BITS; M_ARAddr  out  `AXI_ADDR_BITS; M_ARLen  out  `AXI_LEN_BITS; M_ARSize  out  `AXI_SIZE_BITS; M_ARBurst  out  2; M_ARValid  out  1; M_ARReady  in  1.
- M_RID  in  `AXI_ID_BITS; M_RData  in  `AXI_DATA_BITS; M_RResp  in  2; M_RLast  in  1; M_RValid  in  1; M_RReady  out  1.

## Operation
- States: IDLE, AR, R, DONE. Reset → IDLE.
- IDLE: if fetch_req, capture {fetch_addr[31:2],2'b00} into addr register and go to AR. flush in the same cycle is ignored, and the new address is captured.
- AR: M_ARValid=1, M_ARAddr=addr register. On M_ARValid&M_ARReady → R. M_ARValid never drops before the handshake, even after a flush.
- R: M_RReady=1. On each RValid&RReady beat: the first beat's RData is captured into fetch_data and (RResp!=2'b00) into fetch_err. On the beat with RLast=1: go to DONE, or to IDLE if the drop flag is set. Beats with RLast=0 are consumed and their data is discarded after the first.
- DONE: fetch_valid=(~flush), then → IDLE.
- Drop flag: set by flush in AR or R, cleared on entering IDLE. While set, fetch_data/fetch_err are not updated.
- Constant fields: M_ARID=MASTER_ID, M_ARLen=0, M_ARSize=3'b010, M_ARBurst=2'b01 (INCR). M_RID is not checked (single outstanding transaction).
- One transaction outstanding at most. No request is accepted outside IDLE.

## Timing
- Reset values: M_ARValid=0, M_RReady=0, M_ARAddr=0, fetch_valid=0, fetch_data=0, fetch_err=0. Constant AR fields are driven as stated.
- M_ARValid, M_RReady and fetch_valid are decoded from the registered state only. There is no combinational path from AXI inputs to them.
- Minimum bus latency: fetch_req at cycle 0, M_ARValid at cycle 1, RValid handshake earliest at cycle 2, fetch_valid at cycle 3.
- Against the ROM wrapper (registered ARReady, RValid the cycle after AR handshake): 3 cycles request-to-valid.
- Back-to-back fetches: next request is captured in the IDLE cycle after DONE, giving a 4-cycle minimum period.
- Reset mid-transaction returns to IDLE immediately with outputs at reset values. The slave must be reset by the same ARESETn.

## Configuration
- IM_BUF_EN defined: one-entry fetch buffer (tag[31:2], data, valid).
  - Filled at DONE when fetch_err=0. Invalidated on reset.
  - In IDLE, if fetch_req, tag hit, valid and ~flush: go directly to DONE with the buffered data and no AXI traffic. Hit latency is fetch_valid at cycle 1.
  - A miss behaves as normal.
- IM_BUF_EN undefined: no buffer; every fetch issues an AXI read.

## Test plan
- Basic fetch: addr 0x0000_0104, slave ARReady=1, returns RData 0x0000_0013, OKAY, RLast → ARAddr 0x104, ARLen 0, ARSize 2; fetch_valid at cycle 3 with data 0x13, fetch_err 0.
- AR backpressure: ARReady low for 4 cycles, flush pulsed in cycle 2 → ARValid held until the handshake; the beat is consumed; no fetch_valid; back in IDLE; next request addr 0x200 is fetched normally.
- Error response: RResp=2'b10 (SLVERR), data 0xDEAD_BEEF → fetch_valid with fetch_err=1; buffer not filled (IM_BUF_EN).
- Multi-beat response: slave returns 3 beats 0x11, 0x22, 0x33 with RLast on the third → RReady held for all three; fetch_data=0x11; one fetch_valid pulse.
- Reset mid-R: ARESETn low while in R → next cycle M_RReady=0, fetch_valid=0, fetch_data=0; after release, a fetch of 0x0 completes normally.
- IM_BUF_EN repeat fetch: fetch 0x40, then 0x40 again → second fetch has no ARValid; fetch_valid 1 cycle after the request with the same data.

Source files
------------

// File: rtl/im_fetch_master_if.sv
// ---------------------------------------------------------------------------
// im_fetch_master_if
//   AXI read-address (AR) and read-data (R) channels of the instruction-fetch
//   master. This master is read-only, so there are no AW/W/B signals.
//
//   master modport : drives AR request and RReady, receives ARReady and R data
//   slave  modport : the mirror view (interconnect / boot ROM wrapper side)
//
//   Widths come from the AXI_*_BITS macros; defaults are supplied when the
//   surrounding build has not defined them.
// ---------------------------------------------------------------------------
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif

interface im_fetch_master_if;
  logic [`AXI_ID_BITS-1:0]   M_ARID;
  logic [`AXI_ADDR_BITS-1:0] M_ARAddr;
  logic [`AXI_LEN_BITS-1:0]  M_ARLen;
  logic [`AXI_SIZE_BITS-1:0] M_ARSize;
  logic [1:0]                M_ARBurst;
  logic                      M_ARValid;
  logic                      M_ARReady;

  logic [`AXI_ID_BITS-1:0]   M_RID;
  logic [`AXI_DATA_BITS-1:0] M_RData;
  logic [1:0]                M_RResp;
  logic                      M_RLast;
  logic                      M_RValid;
  logic                      M_RReady;

  modport master (
    output M_ARID, M_ARAddr, M_ARLen, M_ARSize, M_ARBurst, M_ARValid,
    input  M_ARReady,
    input  M_RID, M_RData, M_RResp, M_RLast, M_RValid,
    output M_RReady
  );

  modport slave (
    input  M_ARID, M_ARAddr, M_ARLen, M_ARSize, M_ARBurst, M_ARValid,
    output M_ARReady,
    output M_RID, M_RData, M_RResp, M_RLast, M_RValid,
    input  M_RReady
  );
endinterface

// File: rtl/im_fetch_master.sv
// ---------------------------------------------------------------------------
// im_fetch_master
//   CPU instruction-fetch AXI read master. Each fetch request becomes one
//   single-beat INCR read (ARLen=0, ARSize=word). The first R beat supplies
//   the instruction word; a flush (redirect) while the read is in flight
//   marks it dropped so the response is consumed silently.
//
// Ports
//   ACLK, ARESETn   clock; synchronous active-low reset
//   fetch_req       request, held with fetch_addr until fetch_valid
//   fetch_addr      byte address, bits [1:0] ignored
//   flush           one-cycle redirect pulse
//   fetch_valid     one-cycle pulse, fetch_data / fetch_err valid
//   fetch_data      registered instruction word
//   fetch_err       first beat's RResp was not OKAY
//   fetch_stall     fetch_req & ~fetch_valid
//   m_axi           AR / R channels (im_fetch_master_if.master)
//
// Configuration
//   IM_BUF_EN  when defined, adds a one-entry fetch buffer (tag, data,
//              valid); a hit in IDLE completes with no AXI traffic.
// ---------------------------------------------------------------------------
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif

module im_fetch_master #(
  parameter logic [`AXI_ID_BITS-1:0] MASTER_ID = `AXI_ID_BITS'd0
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_addr,
  input  logic              flush,
  output logic              fetch_valid,
  output logic [31:0]       fetch_data,
  output logic              fetch_err,
  output logic              fetch_stall,
  im_fetch_master_if.master m_axi
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] AR   = 2'd1;
  localparam logic [1:0] R    = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] addr_q,  addr_d;
  logic        drop_q,  drop_d;
  logic        first_q, first_d;   // next R beat is the first of the burst
  logic [31:0] data_q,  data_d;
  logic        err_q,   err_d;

  logic        buf_hit;
  logic        cancel;             // this transaction is being discarded

`ifdef IM_BUF_EN
  logic [29:0] buf_tag_q,   buf_tag_d;
  logic [31:0] buf_data_q,  buf_data_d;
  logic        buf_valid_q, buf_valid_d;

  assign buf_hit = buf_valid_q && (buf_tag_q == fetch_addr[31:2]) && !flush;
`else
  assign buf_hit = 1'b0;
`endif

  // A flush arriving in the same cycle as a beat already counts as dropped,
  // so that beat cannot update the returned word either.
  assign cancel = drop_q | flush;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    drop_d  = drop_q;
    first_d = first_q;
    data_d  = data_q;
    err_d   = err_q;
`ifdef IM_BUF_EN
    buf_tag_d   = buf_tag_q;
    buf_data_d  = buf_data_q;
    buf_valid_d = buf_valid_q;
`endif

    case (state_q)
      IDLE: begin
        // flush is deliberately ignored here: the request is a fresh one.
        if (fetch_req) begin
          addr_d = {fetch_addr[31:2], 2'b00};
          if (buf_hit) begin
`ifdef IM_BUF_EN
            data_d = buf_data_q;
`endif
            err_d   = 1'b0;
            state_d = DONE;
          end else begin
            state_d = AR;
          end
        end
      end

      AR: begin
        if (flush) drop_d = 1'b1;
        // ARValid stays up until the handshake even when dropped.
        if (m_axi.M_ARReady) begin
          state_d = R;
          first_d = 1'b1;
        end
      end

      R: begin
        if (flush) drop_d = 1'b1;
        if (m_axi.M_RValid) begin
          if (first_q && !cancel) begin
            data_d = m_axi.M_RData[31:0];
            err_d  = (m_axi.M_RResp != 2'b00);
          end
          first_d = 1'b0;
          if (m_axi.M_RLast) state_d = cancel ? IDLE : DONE;
        end
      end

      default: begin  // DONE
`ifdef IM_BUF_EN
        if (!err_q) begin
          buf_tag_d   = addr_q[31:2];
          buf_data_d  = data_q;
          buf_valid_d = 1'b1;
        end
`endif
        state_d = IDLE;
      end
    endcase

    if (state_d == IDLE) drop_d = 1'b0;
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      drop_q  <= 1'b0;
      first_q <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
`ifdef IM_BUF_EN
      buf_tag_q   <= '0;
      buf_data_q  <= '0;
      buf_valid_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      drop_q  <= drop_d;
      first_q <= first_d;
      data_q  <= data_d;
      err_q   <= err_d;
`ifdef IM_BUF_EN
      buf_tag_q   <= buf_tag_d;
      buf_data_q  <= buf_data_d;
      buf_valid_q <= buf_valid_d;
`endif
    end
  end

  // Handshake outputs decode the registered state only.
  assign m_axi.M_ARValid = (state_q == AR);
  assign m_axi.M_RReady  = (state_q == R);
  assign m_axi.M_ARAddr  = `AXI_ADDR_BITS'(addr_q);
  assign m_axi.M_ARID    = MASTER_ID;
  assign m_axi.M_ARLen   = '0;
  assign m_axi.M_ARSize  = `AXI_SIZE_BITS'(3'b010);
  assign m_axi.M_ARBurst = 2'b01;

  assign fetch_valid = (state_q == DONE) && !flush;
  assign fetch_data  = data_q;
  assign fetch_err   = err_q;
  assign fetch_stall = fetch_req && !fetch_valid;

  // RID is not needed with a single outstanding read.
  logic unused_ok;
  assign unused_ok = ^{m_axi.M_RID, fetch_addr[1:0]};

endmodule

// File: tb/tb_im_fetch_master.sv
`timescale 1ns/1ps
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif

module tb_im_fetch_master;
  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic        fetch_req = 1'b0;
  logic [31:0] fetch_addr = '0;
  logic        flush = 1'b0;
  logic        fetch_valid;
  logic [31:0] fetch_data;
  logic        fetch_err;
  logic        fetch_stall;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference state: what fetch_data/fetch_err should hold, and buffer image.
  logic [31:0] m_data = '0;
  logic        m_err = 1'b0;
  logic        bm_valid = 1'b0;
  logic [29:0] bm_tag = '0;
  logic [31:0] bm_data = '0;

  im_fetch_master_if bus();

  im_fetch_master #(.MASTER_ID(`AXI_ID_BITS'(5))) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .flush(flush),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data), .fetch_err(fetch_err),
    .fetch_stall(fetch_stall), .m_axi(bus.master)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge ACLK);
      fetch_req = 1'b0; flush = 1'b0;
      bus.M_ARReady = 1'b0; bus.M_RValid = 1'b0;
    end
  endtask

  // One CPU fetch against a bench AXI slave. flush_cyc is the cycle (0 = the
  // request cycle) at which flush pulses; -1 means no flush. Expectations are
  // derived from the timing rules: AR from cycle 1, handshake after ar_delay
  // stall cycles, R data r_delay cycles later, DONE one cycle after RLast.
  task automatic run_fetch(input logic [31:0] addr, input logic [31:0] rdata,
                           input logic [1:0] resp, input int nbeats,
                           input int ar_delay, input int r_delay, input int flush_cyc,
                           output logic got_valid, output logic [31:0] got_data,
                           output logic got_err);
    bit hit, drop, exp_v, ar_done;
    int h, c_first, l, beat, rwait;
    logic [31:0] nd;
    logic ne;

    hit = 1'b0;
`ifdef IM_BUF_EN
    hit = bm_valid && (bm_tag == addr[31:2]) && (flush_cyc != 0);
`endif
    if (hit) begin
      h = 0; c_first = -1; l = 0;
      nd = bm_data; ne = 1'b0;
    end else begin
      h = 1 + ar_delay; c_first = h + 1 + r_delay; l = c_first + nbeats - 1;
      if (flush_cyc >= 1 && flush_cyc <= c_first) begin nd = m_data; ne = m_err; end
      else begin nd = rdata; ne = (resp != 2'b00); end
    end
    drop  = !hit && flush_cyc >= 1 && flush_cyc <= l;
    exp_v = !drop && (flush_cyc != l + 1);

    got_valid = 1'b0; got_data = '0; got_err = 1'b0;
    ar_done = 1'b0; beat = 0; rwait = 0;

    for (int c = 0; c <= l + 1; c++) begin
      @(negedge ACLK);
      if (c == 0) begin fetch_req = 1'b1; fetch_addr = addr; end
      flush = (c == flush_cyc);
      if (c >= 1 && c == flush_cyc) fetch_req = 1'b0;
      bus.M_ARReady = !ar_done && (c >= 1 + ar_delay);
      bus.M_RValid  = ar_done && (beat < nbeats) && (rwait >= r_delay);
      bus.M_RData   = `AXI_DATA_BITS'(rdata * (beat + 1));
      bus.M_RResp   = (beat == 0) ? resp : 2'b10;
      bus.M_RLast   = (beat == nbeats - 1);
      bus.M_RID     = '0;
      #1;
      check("arvalid", 32'(bus.M_ARValid), 32'(c >= 1 && c <= h));
      check("rready", 32'(bus.M_RReady), 32'(c > h && c <= l));
      check("fetch_valid", 32'(fetch_valid), 32'(c == l + 1 && exp_v));
      check("fetch_stall", 32'(fetch_stall), 32'(fetch_req && !(c == l + 1 && exp_v)));
      if (c == 1 && !hit) check("araddr", 32'(bus.M_ARAddr), {addr[31:2], 2'b00});
      if (c == l + 1) begin
        check("fetch_data", fetch_data, nd);
        check("fetch_err", 32'(fetch_err), 32'(ne));
      end
      if (fetch_valid) begin got_valid = 1'b1; got_data = fetch_data; got_err = fetch_err; end
      if (ar_done) begin
        if (bus.M_RValid && bus.M_RReady) beat++;
        else if (rwait < r_delay) rwait++;
      end
      if (bus.M_ARValid && bus.M_ARReady) ar_done = 1'b1;
    end
    bus.M_ARReady = 1'b0; bus.M_RValid = 1'b0;

    m_data = nd; m_err = ne;
    if (!drop && !ne) begin bm_valid = 1'b1; bm_tag = addr[31:2]; bm_data = nd; end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [1:0]  resp;
    int          nbeats;
    int          ar_delay;
    int          r_delay;
    int          flush_cyc;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  initial begin
    vec_t vt[8];
    logic gv, ge;
    logic [31:0] gd;
    logic [31:0] first40;

    vt[0] = '{32'h0000_0104, 32'h0000_0013, 2'b00, 1, 0, 0, -1, 1'b1, 32'h0000_0013, 1'b0};
    vt[1] = '{32'h0000_01F0, 32'h0000_0055, 2'b00, 1, 4, 0,  2, 1'b0, 32'h0,        1'b0};
    vt[2] = '{32'h0000_0200, 32'hA5A5_0001, 2'b00, 1, 0, 0, -1, 1'b1, 32'hA5A5_0001, 1'b0};
    vt[3] = '{32'h0000_0308, 32'hDEAD_BEEF, 2'b10, 1, 0, 1, -1, 1'b1, 32'hDEAD_BEEF, 1'b1};
    vt[4] = '{32'h0000_0400, 32'h0000_0011, 2'b00, 3, 1, 0, -1, 1'b1, 32'h0000_0011, 1'b0};
    vt[5] = '{32'h0000_0507, 32'h0000_0077, 2'b00, 1, 2, 2,  0, 1'b1, 32'h0000_0077, 1'b0};
    vt[6] = '{32'h0000_0600, 32'h0000_0099, 2'b00, 1, 0, 0,  3, 1'b0, 32'h0,        1'b0};
    vt[7] = '{32'h0000_0700, 32'h0000_0012, 2'b00, 2, 0, 0,  3, 1'b0, 32'h0,        1'b0};

    bus.M_ARReady = 1'b0; bus.M_RValid = 1'b0; bus.M_RData = '0;
    bus.M_RResp = 2'b00; bus.M_RLast = 1'b0; bus.M_RID = '0;

    // Reset state and constant AR fields
    repeat (3) @(negedge ACLK);
    check("rst_arvalid", 32'(bus.M_ARValid), 32'h0);
    check("rst_rready", 32'(bus.M_RReady), 32'h0);
    check("rst_araddr", 32'(bus.M_ARAddr), 32'h0);
    check("rst_valid", 32'(fetch_valid), 32'h0);
    check("rst_data", fetch_data, 32'h0);
    check("rst_err", 32'(fetch_err), 32'h0);
    check("arid", 32'(bus.M_ARID), 32'h5);
    check("arlen", 32'(bus.M_ARLen), 32'h0);
    check("arsize", 32'(bus.M_ARSize), 32'h2);
    check("arburst", 32'(bus.M_ARBurst), 32'h1);
    ARESETn = 1'b1;
    idle(2);

    // Directed vectors
    for (int i = 0; i < 8; i++) begin
      run_fetch(vt[i].addr, vt[i].rdata, vt[i].resp, vt[i].nbeats,
                vt[i].ar_delay, vt[i].r_delay, vt[i].flush_cyc, gv, gd, ge);
      check($sformatf("vec%0d_valid", i), 32'(gv), 32'(vt[i].exp_valid));
      if (vt[i].exp_valid) begin
        check($sformatf("vec%0d_data", i), gd, vt[i].exp_data);
        check($sformatf("vec%0d_err", i), 32'(ge), 32'(vt[i].exp_err));
      end
      idle(1);
    end

    // Multi-beat result must leave a nonzero word before the reset test
    run_fetch(32'h0000_0800, 32'h0000_0011, 2'b00, 3, 0, 0, -1, gv, gd, ge);
    check("mb_data", gd, 32'h0000_0011);

    // Reset while waiting in R
    @(negedge ACLK);
    fetch_req = 1'b1; fetch_addr = 32'h0000_0300; bus.M_ARReady = 1'b1; bus.M_RValid = 1'b0;
    @(negedge ACLK);
    check("rstR_arvalid", 32'(bus.M_ARValid), 32'h1);
    @(negedge ACLK);
    bus.M_ARReady = 1'b0;
    check("rstR_in_r", 32'(bus.M_RReady), 32'h1);
    ARESETn = 1'b0; fetch_req = 1'b0;
    @(negedge ACLK);
    check("rstR_rready", 32'(bus.M_RReady), 32'h0);
    check("rstR_arvalid0", 32'(bus.M_ARValid), 32'h0);
    check("rstR_valid", 32'(fetch_valid), 32'h0);
    check("rstR_data", fetch_data, 32'h0);
    check("rstR_araddr", 32'(bus.M_ARAddr), 32'h0);
    ARESETn = 1'b1;
    m_data = '0; m_err = 1'b0; bm_valid = 1'b0;
    run_fetch(32'h0000_0000, 32'h1234_5678, 2'b00, 1, 0, 0, -1, gv, gd, ge);
    check("post_rst_valid", 32'(gv), 32'h1);
    check("post_rst_data", gd, 32'h1234_5678);

    // Back-to-back fetches, 4-cycle period
    run_fetch(32'h0000_0900, 32'h0000_0A01, 2'b00, 1, 0, 0, -1, gv, gd, ge);
    run_fetch(32'h0000_0904, 32'h0000_0A02, 2'b00, 1, 0, 0, -1, gv, gd, ge);
    check("b2b_data", gd, 32'h0000_0A02);

`ifdef IM_BUF_EN
    // Repeat fetch served from the buffer (no ARValid, valid at cycle 1)
    idle(1);
    run_fetch(32'h0000_0040, 32'hCAFE_0040, 2'b00, 1, 0, 0, -1, gv, gd, ge);
    first40 = gd;
    run_fetch(32'h0000_0040, 32'h0BAD_0BAD, 2'b00, 1, 0, 0, -1, gv, gd, ge);
    check("buf_hit_valid", 32'(gv), 32'h1);
    check("buf_hit_data", gd, first40);
    // Error response is never buffered
    run_fetch(32'h0000_0044, 32'hDEAD_BEEF, 2'b10, 1, 0, 0, -1, gv, gd, ge);
    check("buf_err", 32'(ge), 32'h1);
    run_fetch(32'h0000_0044, 32'h0000_0044, 2'b00, 1, 0, 0, -1, gv, gd, ge);
    check("buf_err_refetch", gd, 32'h0000_0044);
`else
    first40 = '0;
`endif

    // Randomized traffic against the reference model
    for (int i = 0; i < 200; i++) begin
      logic [31:0] ra;
      logic [1:0]  rr;
      int fc;
      ra = 32'h0000_1000 + 32'($urandom_range(0, 5) << 2) + 32'($urandom_range(0, 3));
      rr = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      fc = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 9)) : -1;
      run_fetch(ra, $urandom, rr, int'($urandom_range(1, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), fc, gv, gd, ge);
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 2)));
    end

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
